// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_ldr_pkg;
  localparam int WORDS = 32;
  localparam int AW    = 5;
  localparam int LEN_W = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    RUN   = 3'd3,
    ERROR = 3'd4
  } ldr_state_t;

  // Requested lengths beyond the memory depth load the whole memory.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len > LEN_W'(WORDS)) begin
      return LEN_W'(WORDS);
    end else begin
      return len;
    end
  endfunction
endpackage

// File: rtl/imem_boot_loader_if.sv
// Host-side bus of the boot loader: control, byte stream, memory ports and CPU status.
interface imem_boot_loader_if;
  import imem_ldr_pkg::*;

  logic                 start_i;
  logic [LEN_W-1:0]     len_i;
  logic [7:0]           byte_data_i;
  logic                 byte_valid_i;
  logic                 byte_ready_o;
  logic [31:0]          cpu_pc_i;
  logic [AW-1:0]        mem_raddr_o;
  logic                 mem_we_o;
  logic [AW-1:0]        mem_waddr_o;
  logic [31:0]          mem_wdata_o;
  logic                 cpu_rst_n_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 err_o;
  logic                 misalign_o;

  modport master (
    output start_i, len_i, byte_data_i, byte_valid_i, cpu_pc_i,
    input  byte_ready_o, mem_raddr_o, mem_we_o, mem_waddr_o, mem_wdata_o,
           cpu_rst_n_o, busy_o, done_o, err_o, misalign_o
  );

  modport slave (
    input  start_i, len_i, byte_data_i, byte_valid_i, cpu_pc_i,
    output byte_ready_o, mem_raddr_o, mem_we_o, mem_waddr_o, mem_wdata_o,
           cpu_rst_n_o, busy_o, done_o, err_o, misalign_o
  );
endinterface

// File: rtl/imem_boot_loader_byte_packer.sv
// Packs accepted stream bytes into little-endian 32-bit words; the completed
// word is presented combinationally in the cycle of the fourth handshake.
module byte_packer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);
  logic [1:0]  cnt_r;
  logic [23:0] hold_r;

  assign word_valid_o = accept_i && (cnt_r == 2'd3);
  assign word_o       = {byte_i, hold_r};

  // Byte counter and holding register for the first three bytes of a word.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_r  <= 2'd0;
      hold_r <= 24'd0;
    end else if (clr_i) begin
      cnt_r  <= 2'd0;
      hold_r <= 24'd0;
    end else if (accept_i) begin
      cnt_r <= cnt_r + 2'd1;
      case (cnt_r)
        2'd0:    hold_r[7:0]   <= byte_i;
        2'd1:    hold_r[15:8]  <= byte_i;
        2'd2:    hold_r[23:16] <= byte_i;
        default: hold_r        <= hold_r;
      endcase
    end else begin
      cnt_r  <= cnt_r;
      hold_r <= hold_r;
    end
  end
endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader top: load FSM, word counter, running checksum and fetch-address path.
module imem_boot_loader
  import imem_ldr_pkg::*;
(
  input logic          clk_i,
  input logic          rst_i,
  imem_boot_loader_if.slave bus
);
  ldr_state_t       state_r, state_s;
  logic [LEN_W-1:0] len_r, len_s;
  logic [LEN_W-1:0] wcnt_r, wcnt_s, wcnt_inc_s;
  logic [31:0]      sum_r, sum_s;
  logic             we_r, we_s;
  logic [AW-1:0]    waddr_r, waddr_s;
  logic [31:0]      wdata_r, wdata_s;
  logic             clr_s, accept_s;
  logic [31:0]      word_s;
  logic             word_valid_s;
  logic             byte_ready_r, busy_r, done_r, err_r, cpu_rst_n_r;
  logic             unused_pc_s;

  assign accept_s   = bus.byte_valid_i && byte_ready_r;
  assign wcnt_inc_s = wcnt_r + 6'd1;

  byte_packer u_packer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clr_i        (clr_s),
    .accept_i     (accept_s),
    .byte_i       (bus.byte_data_i),
    .word_o       (word_s),
    .word_valid_o (word_valid_s)
  );

  // Next-state and datapath update decisions.
  always_comb begin
    state_s = state_r;
    len_s   = len_r;
    wcnt_s  = wcnt_r;
    sum_s   = sum_r;
    we_s    = 1'b0;
    waddr_s = waddr_r;
    wdata_s = wdata_r;
    clr_s   = 1'b0;
    case (state_r)
      IDLE, RUN, ERROR: begin
        if (bus.start_i) begin
          len_s   = clamp_len(bus.len_i);
          wcnt_s  = 6'd0;
          sum_s   = 32'd0;
          clr_s   = 1'b1;
          state_s = (clamp_len(bus.len_i) == 6'd0) ? CHECK : LOAD;
        end else begin
          state_s = state_r;
        end
      end
      LOAD: begin
        if (word_valid_s) begin
          if (wcnt_r < LEN_W'(WORDS)) begin
            we_s    = 1'b1;
            waddr_s = wcnt_r[AW-1:0];
            wdata_s = word_s;
          end else begin
            we_s = 1'b0;
          end
          sum_s  = sum_r + word_s;
          wcnt_s = wcnt_inc_s;
          if (wcnt_inc_s == len_r) begin
            state_s = CHECK;
          end else begin
            state_s = LOAD;
          end
        end else begin
          state_s = LOAD;
        end
      end
      CHECK: begin
        if (word_valid_s) begin
          state_s = (word_s == sum_r) ? RUN : ERROR;
        end else begin
          state_s = CHECK;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, datapath and status registers; status flags decode the next state
  // so they change in the same cycle as the state itself.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r      <= IDLE;
      len_r        <= 6'd0;
      wcnt_r       <= 6'd0;
      sum_r        <= 32'd0;
      we_r         <= 1'b0;
      waddr_r      <= {AW{1'b0}};
      wdata_r      <= 32'd0;
      byte_ready_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      cpu_rst_n_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      len_r        <= len_s;
      wcnt_r       <= wcnt_s;
      sum_r        <= sum_s;
      we_r         <= we_s;
      waddr_r      <= waddr_s;
      wdata_r      <= wdata_s;
      byte_ready_r <= (state_s == LOAD) || (state_s == CHECK);
      busy_r       <= (state_s == LOAD) || (state_s == CHECK);
      done_r       <= (state_s == RUN);
      err_r        <= (state_s == ERROR);
      cpu_rst_n_r  <= (state_s == RUN);
    end
  end

  assign bus.byte_ready_o = byte_ready_r;
  assign bus.mem_we_o     = we_r;
  assign bus.mem_waddr_o  = waddr_r;
  assign bus.mem_wdata_o  = wdata_r;
  assign bus.busy_o       = busy_r;
  assign bus.done_o       = done_r;
  assign bus.err_o        = err_r;
  assign bus.cpu_rst_n_o  = cpu_rst_n_r;
  assign bus.mem_raddr_o  = bus.cpu_pc_i[AW+1:2];
  assign bus.misalign_o   = done_r && (bus.cpu_pc_i[1:0] != 2'b00);
  assign unused_pc_s      = ^bus.cpu_pc_i[31:AW+2];
endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed scenarios plus random words
// and random stream gaps checked against a list-level model of the expected writes.
module tb_imem_boot_loader;
  import imem_ldr_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  imem_boot_loader_if bus();

  imem_boot_loader dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] wbuf [40];
  logic [36:0] obs_q [$];

  always @(negedge clk) begin
    if (bus.mem_we_o === 1'b1) obs_q.push_back({bus.mem_waddr_o, bus.mem_wdata_o});
  end

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // Offer one byte at a negedge and return at the negedge after its handshake.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps) begin
      bus.byte_valid_i = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    bus.byte_data_i  = b;
    bus.byte_valid_i = 1'b1;
    t = 0;
    while (bus.byte_ready_o !== 1'b1 && t < 16) begin
      @(negedge clk);
      t++;
    end
    if (t >= 16) chk("ready_timeout", bus.byte_ready_o, 1);
    @(negedge clk);
    bus.byte_valid_i = 1'b0;
  endtask

  // Full load of wbuf[0..] with the given length and checksum word.
  task automatic run_load(input logic [5:0] len, input logic [31:0] ck, input bit gaps);
    int          nw;
    logic [31:0] sum;
    bit          ok;
    nw  = (len > 6'd32) ? 32 : int'(len);
    sum = 32'd0;
    for (int i = 0; i < nw; i++) sum = sum + wbuf[i];
    ok = (sum == ck);
    obs_q.delete();
    bus.len_i   = len;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    chk("start_busy", bus.busy_o, 1);
    chk("start_ready", bus.byte_ready_o, 1);
    chk("start_cpu_rst", bus.cpu_rst_n_o, 0);
    for (int w = 0; w < nw; w++) begin
      for (int k = 0; k < 4; k++) begin
        send_byte(wbuf[w][8*k +: 8], gaps);
        chk("we_latency", bus.mem_we_o, (k == 3) ? 1 : 0);
      end
    end
    for (int k = 0; k < 4; k++) begin
      send_byte(ck[8*k +: 8], gaps);
      chk("chk_no_we", bus.mem_we_o, 0);
    end
    chk("res_done", bus.done_o, ok);
    chk("res_err", bus.err_o, !ok);
    chk("res_cpu_rst_n", bus.cpu_rst_n_o, ok);
    chk("res_ready", bus.byte_ready_o, 0);
    chk("res_busy", bus.busy_o, 0);
    #1;
    chk("n_writes", obs_q.size(), nw);
    for (int i = 0; i < nw && i < obs_q.size(); i++) begin
      chk("waddr", obs_q[i][36:32], i);
      chk("wdata", obs_q[i][31:0], wbuf[i]);
    end
  endtask

  initial begin
    bus.start_i      = 1'b1;
    bus.len_i        = 6'd3;
    bus.byte_data_i  = 8'h00;
    bus.byte_valid_i = 1'b0;
    bus.cpu_pc_i     = 32'h0000_007E;
    rst              = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.byte_ready_o, 0);
    chk("rst_we", bus.mem_we_o, 0);
    chk("rst_waddr", bus.mem_waddr_o, 0);
    chk("rst_wdata", bus.mem_wdata_o, 0);
    chk("rst_cpu_rst_n", bus.cpu_rst_n_o, 0);
    chk("rst_flags", {bus.busy_o, bus.done_o, bus.err_o, bus.misalign_o}, 4'b0000);
    chk("rst_raddr", bus.mem_raddr_o, 31);
    bus.cpu_pc_i = 32'h0000_0008;
    #1;
    chk("rst_raddr2", bus.mem_raddr_o, 2);
    bus.start_i = 1'b0;
    rst         = 1'b1;
    @(negedge clk);
    chk("idle_busy", bus.busy_o, 0);

    // Good load, then the same data with a bad checksum.
    wbuf[0] = 32'h8C01_0000;
    wbuf[1] = 32'h2002_0005;
    run_load(6'd2, 32'hAC03_0005, 1'b0);
    run_load(6'd2, 32'hAC03_0006, 1'b0);
    chk("err_cpu_held", bus.cpu_rst_n_o, 0);

    // Zero length leaves ERROR and reaches RUN with no writes; then clamp to 32.
    run_load(6'd0, 32'h0000_0000, 1'b0);
    for (int i = 0; i < 40; i++) wbuf[i] = $urandom;
    begin
      logic [31:0] s;
      s = 32'd0;
      for (int i = 0; i < 32; i++) s = s + wbuf[i];
      run_load(6'd40, s, 1'b0);
      for (int i = 0; i < 5; i++) wbuf[i] = $urandom;
      s = 32'd0;
      for (int i = 0; i < 5; i++) s = s + wbuf[i];
      run_load(6'd5, s, 1'b1);
      run_load(6'd5, s ^ (32'd1 << $urandom_range(0, 31)), 1'b1);
      run_load(6'd5, s, 1'b1);
    end

    // Fetch path in RUN.
    bus.cpu_pc_i = 32'h0000_0014;
    #1;
    chk("fetch_raddr", bus.mem_raddr_o, 5);
    chk("fetch_misalign0", bus.misalign_o, 0);
    bus.cpu_pc_i = 32'h0000_0016;
    #1;
    chk("fetch_misalign1", bus.misalign_o, 1);
    @(negedge clk);

    // Restart from RUN, then reset after the first word.
    obs_q.delete();
    bus.len_i   = 6'd4;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    chk("rerun_cpu_rst", bus.cpu_rst_n_o, 0);
    chk("rerun_misalign", bus.misalign_o, 0);
    for (int k = 0; k < 4; k++) send_byte(wbuf[0][8*k +: 8], 1'b0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mid_rst_busy", bus.busy_o, 0);
    chk("mid_rst_ready", bus.byte_ready_o, 0);
    bus.byte_valid_i = 1'b1;
    repeat (6) @(negedge clk);
    bus.byte_valid_i = 1'b0;
    #1;
    chk("mid_rst_writes", obs_q.size(), 1);
    chk("mid_rst_done", bus.done_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
